// File: rtl/result_demux_1to4.sv
// Registered 1-to-4 result demultiplexer: steers each accepted word by sel into
// one of four per-channel FIFOs; reserved-channel words may be dropped and counted.
module result_demux_1to4 #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter int CNT_W     = 8,
  parameter int DROP_RESV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]   drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem   [4][DEPTH];
  logic [AW-1:0]    wptr  [4];
  logic [AW-1:0]    rptr  [4];
  logic [CW-1:0]    count [4];

  logic is_drop;
  logic push;
  logic [3:0] push_ch;
  logic [3:0] pop_ch;

  // Ready depends only on registered occupancy, never on out_ready.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    is_drop  = (DROP_RESV != 0) && (sel == 2'd3);
    in_ready = 1'b1;
    if (!is_drop) in_ready = (count[sel] != FULL);
    push = in_valid && in_ready;
    for (int k = 0; k < 4; k++) begin
      push_ch[k]   = push && !is_drop && (sel == 2'(k));
      out_valid[k] = (count[k] != '0);
      pop_ch[k]    = out_valid[k] && out_ready[k];
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < 4; k++)
      if (out_valid[k]) out_data[k*WIDTH +: WIDTH] = mem[k][rptr[k]];
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        wptr[k]  <= '0;
        rptr[k]  <= '0;
        count[k] <= '0;
      end
      drop_cnt <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (push_ch[k]) wptr[k] <= wptr[k] + 1'b1;
        if (pop_ch[k])  rptr[k] <= rptr[k] + 1'b1;
        if (push_ch[k] && !pop_ch[k])      count[k] <= count[k] + 1'b1;
        else if (pop_ch[k] && !push_ch[k]) count[k] <= count[k] - 1'b1;
      end
      if (push && is_drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // NOTE: storage is not reset; out_data masks empty channels so stale words never escape.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (push_ch[k]) mem[k][wptr[k]] <= in_data;
  end

endmodule

// File: tb/tb_result_demux_1to4.sv
// Self-checking bench for result_demux_1to4: directed vector table, hand-written
// corner sequences (drop saturation, async reset) and a queue-model random run.
module tb_result_demux_1to4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [3:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  result_demux_1to4 #(.WIDTH(4), .DEPTH(2), .CNT_W(8), .DROP_RESV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       iv;
    logic [1:0] sel;
    logic [3:0] d;
    logic [3:0] ordy;
    logic       exp_ir;    // in_ready before the edge
    logic [3:0] exp_ov;    // out_valid after the edge
    logic [15:0] exp_od;   // out_data after the edge
    logic [7:0] exp_drop;  // drop_cnt after the edge
  } vec_t;

  vec_t vecs[15];

  logic [3:0] mq [4][$];
  logic [7:0] mdrop;

  initial begin
    logic        exp_ir;
    logic [3:0]  exp_ov;
    logic [15:0] exp_od;

    vecs[0]  = '{1'b1, 2'd0, 4'hA, 4'b0000, 1'b1, 4'b0001, 16'h000A, 8'd0};
    vecs[1]  = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 4'b0011, 16'h003A, 8'd0};
    vecs[2]  = '{1'b1, 2'd1, 4'h5, 4'b0000, 1'b1, 4'b0011, 16'h003A, 8'd0};
    vecs[3]  = '{1'b1, 2'd1, 4'h7, 4'b0000, 1'b0, 4'b0011, 16'h003A, 8'd0};
    vecs[4]  = '{1'b1, 2'd1, 4'h7, 4'b0010, 1'b0, 4'b0011, 16'h005A, 8'd0};
    vecs[5]  = '{1'b1, 2'd1, 4'h7, 4'b0010, 1'b1, 4'b0011, 16'h007A, 8'd0};
    vecs[6]  = '{1'b0, 2'd1, 4'h0, 4'b0010, 1'b1, 4'b0001, 16'h000A, 8'd0};
    vecs[7]  = '{1'b1, 2'd2, 4'h4, 4'b0000, 1'b1, 4'b0101, 16'h040A, 8'd0};
    vecs[8]  = '{1'b1, 2'd2, 4'h9, 4'b0100, 1'b1, 4'b0101, 16'h090A, 8'd0};
    vecs[9]  = '{1'b1, 2'd3, 4'hF, 4'b0000, 1'b1, 4'b0101, 16'h090A, 8'd1};
    vecs[10] = '{1'b1, 2'd0, 4'hB, 4'b0000, 1'b1, 4'b0101, 16'h090A, 8'd1};
    vecs[11] = '{1'b1, 2'd0, 4'hC, 4'b0000, 1'b0, 4'b0101, 16'h090A, 8'd1};
    vecs[12] = '{1'b1, 2'd2, 4'hC, 4'b0000, 1'b1, 4'b0101, 16'h090A, 8'd1};
    vecs[13] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b0, 4'b0101, 16'h0C0B, 8'd1};
    vecs[14] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'h0000, 8'd1};

    rst_n = 1'b0; in_valid = 1'b0; sel = 2'd0; in_data = '0; out_ready = '0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset out_data",  32'(out_data),  32'h0);
    check("reset drop_cnt",  32'(drop_cnt),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: drive at negedge, in_ready just after, outputs one edge later.
    for (int i = 0; i < 15; i++) begin
      in_valid = vecs[i].iv; sel = vecs[i].sel; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ir));
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_od));
      check($sformatf("vec%0d drop_cnt", i),  32'(drop_cnt),  32'(vecs[i].exp_drop));
    end

    // 300 reserved pushes: always ready, never visible, counter saturates.
    in_valid = 1'b1; sel = 2'd3; out_ready = '0;
    for (int i = 0; i < 300; i++) begin
      in_data = 4'(i);
      #1;
      check("drop in_ready", 32'(in_ready), 32'h1);
      @(posedge clk);
      @(negedge clk);
      check("drop out_valid3", 32'(out_valid[3]), 32'h0);
    end
    check("drop_cnt saturated", 32'(drop_cnt), 32'd255);
    in_valid = 1'b0;

    // Fill channel 0, then reset between edges: clears without a clock.
    sel = 2'd0; in_valid = 1'b1;
    in_data = 4'h1; @(posedge clk); @(negedge clk);
    in_data = 4'h2; @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("pre-reset out_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", 32'(out_valid), 32'h0);
    check("async reset out_data",  32'(out_data),  32'h0);
    check("async reset drop_cnt",  32'(drop_cnt),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; sel = 2'd0; in_data = 4'hD;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("post-reset out_valid", 32'(out_valid), 32'h1);
    check("post-reset out_data",  32'(out_data),  32'h000D);

    // Clean restart for the random run against per-channel reference queues.
    rst_n = 1'b0; #2; @(negedge clk); rst_n = 1'b1;
    mdrop = '0;
    for (int k = 0; k < 4; k++) mq[k].delete();
    for (int c = 0; c < 10000; c++) begin
      exp_ov = '0; exp_od = '0;
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0) begin
          exp_ov[k] = 1'b1;
          exp_od[k*4 +: 4] = mq[k][0];
        end
      check("rand out_valid", 32'(out_valid), 32'(exp_ov));
      check("rand out_data",  32'(out_data),  32'(exp_od));
      check("rand drop_cnt",  32'(drop_cnt),  32'(mdrop));

      in_valid  = ($urandom_range(0, 9) < 7);
      sel       = 2'($urandom_range(0, 3));
      in_data   = 4'($urandom_range(0, 15));
      out_ready = 4'($urandom_range(0, 15));
      exp_ir = (sel == 2'd3) ? 1'b1 : (mq[sel].size() != 2);
      #1;
      check("rand in_ready", 32'(in_ready), 32'(exp_ir));

      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
      if (in_valid && exp_ir) begin
        if (sel == 2'd3) begin
          if (mdrop != 8'hFF) mdrop = mdrop + 8'd1;
        end else begin
          mq[sel].push_back(in_data);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
